// File: rtl/instr_fetch_cache_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_cache_if
//   Bundles the fetch-side lookup signals and the backing-memory refill
//   handshake of instr_fetch_cache.
//
//   Fetch side : pc_addr, inv_all (to cache)  /  hit, instr (from cache)
//   Memory side: mem_ready, mem_rdata (to cache) / mem_req, mem_addr (from cache)
//
//   slave  : the cache itself
//   master : the environment (fetch stage + backing memory)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface instr_fetch_cache_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] pc_addr;
   logic              inv_all;
   logic              hit;
   logic [31:0]       instr;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic [31:0]       mem_rdata;

   modport slave (
      input  pc_addr,
      input  inv_all,
      input  mem_ready,
      input  mem_rdata,
      output hit,
      output instr,
      output mem_req,
      output mem_addr
   );

   modport master (
      output pc_addr,
      output inv_all,
      output mem_ready,
      output mem_rdata,
      input  hit,
      input  instr,
      input  mem_req,
      input  mem_addr
   );
endinterface

// File: rtl/instr_fetch_cache.sv
// -----------------------------------------------------------------------------
// instr_fetch_cache
//   Direct-mapped instruction cache for the fetch stage. Each fetch returns one
//   32-bit word (memory-slot instruction in [31:16], ALU-slot in [15:0]).
//   Lines hold two words; a miss refills the whole line from backing memory
//   with two req/ready handshakes (word 0 then word 1).
//
// Ports
//   clk            : rising-edge clock
//   reset          : synchronous, active-low
//   bus.pc_addr    : fetch byte address (bits [1:0] ignored)
//   bus.inv_all    : invalidate every line
//   bus.hit        : instr valid for pc_addr this cycle (combinational)
//   bus.instr      : fetched word, 0 when hit is low
//   bus.mem_req    : backing-memory read request
//   bus.mem_addr   : word-aligned backing read address
//   bus.mem_ready  : one-cycle accept/data-valid pulse
//   bus.mem_rdata  : backing read data
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module instr_fetch_cache #(
   parameter int INDEX_BITS = 3,
   parameter int ADDR_W     = 32
) (
   input  logic               clk,
   input  logic               reset,
   instr_fetch_cache_if.slave bus
);
   localparam int LINES  = 1 << INDEX_BITS;
   localparam int LINE_W = ADDR_W - 3;
   localparam int TAG_W  = ADDR_W - 3 - INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL0 = 2'd1,
      S_FILL1 = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic [LINE_W-1:0]   line_q, line_d;      // line address being refilled
   logic                poison_q, poison_d;  // fill overlapped an invalidate
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

   // Tag/data storage is read asynchronously: a hit must be reported in the
   // same cycle the address is presented.
   logic [TAG_W-1:0]    tag_mem   [LINES];
   logic [31:0]         data0_mem [LINES];
   logic [31:0]         data1_mem [LINES];

   logic [INDEX_BITS-1:0] pc_index;
   logic [INDEX_BITS-1:0] fill_index;
   logic [TAG_W-1:0]      pc_tag;
   logic [TAG_W-1:0]      fill_tag;
   logic                  pc_offset;
   logic                  lookup_hit;
   logic                  wr_word0;
   logic                  wr_word1;
   logic                  hit_c;
   logic [31:0]           instr_c;
   logic                  unused_pc_bits;

   // ---------------------------------------------------------------- address
   assign pc_offset  = bus.pc_addr[2];
   assign pc_index   = bus.pc_addr[2+INDEX_BITS:3];
   assign pc_tag     = bus.pc_addr[ADDR_W-1:3+INDEX_BITS];
   assign fill_index = line_q[INDEX_BITS-1:0];
   assign fill_tag   = line_q[LINE_W-1:INDEX_BITS];

   // Byte-within-word bits carry no information for a word fetch.
   assign unused_pc_bits = ^bus.pc_addr[1:0];

   assign lookup_hit = valid_q[pc_index] && (tag_mem[pc_index] == pc_tag);

   // ---------------------------------------------------------- next state
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      line_d     = line_q;
      poison_d   = poison_q;
      mem_addr_d = mem_addr_q;
      wr_word0   = 1'b0;
      wr_word1   = 1'b0;
      hit_c      = 1'b0;
      instr_c    = 32'h0;

      unique case (state_q)
         S_IDLE: begin
            if (!bus.inv_all) begin
               if (lookup_hit) begin
                  hit_c   = 1'b1;
                  instr_c = pc_offset ? data1_mem[pc_index] : data0_mem[pc_index];
               end else begin
                  state_d    = S_FILL0;
                  line_d     = bus.pc_addr[ADDR_W-1:3];
                  mem_addr_d = {bus.pc_addr[ADDR_W-1:3], 3'b000};
                  poison_d   = 1'b0;
                  // Word 0 is overwritten before the new tag lands; drop the
                  // old line now so a half-written line can never look valid.
                  valid_d[pc_index] = 1'b0;
               end
            end
         end

         S_FILL0: begin
            if (bus.mem_ready) begin
               wr_word0   = 1'b1;
               state_d    = S_FILL1;
               mem_addr_d = {line_q, 3'b100};
            end
         end

         S_FILL1: begin
            if (bus.mem_ready) begin
               wr_word1 = 1'b1;
               state_d  = S_IDLE;
               if (!poison_q && !bus.inv_all) begin
                  valid_d[fill_index] = 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Invalidate wins over everything, including a line completing now.
      if (bus.inv_all) begin
         valid_d = '0;
         if (state_q != S_IDLE) begin
            poison_d = 1'b1;
         end
      end
   end

   // ------------------------------------------------------ control registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         valid_q    <= '0;
         line_q     <= '0;
         poison_q   <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         line_q     <= line_d;
         poison_q   <= poison_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   // ------------------------------------------------------ tag/data storage
   always_ff @(posedge clk) begin
      if (reset && wr_word0) begin
         data0_mem[fill_index] <= bus.mem_rdata;
      end
      if (reset && wr_word1) begin
         data1_mem[fill_index] <= bus.mem_rdata;
         tag_mem[fill_index]   <= fill_tag;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.hit      = hit_c;
   assign bus.instr    = instr_c;
   assign bus.mem_req  = (state_q != S_IDLE);
   assign bus.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch_cache.sv
`timescale 1ns/1ps

module tb_instr_fetch_cache;
   logic clk;
   logic reset;

   instr_fetch_cache_if #(.ADDR_W(32)) bus();

   instr_fetch_cache #(
      .INDEX_BITS(3),
      .ADDR_W    (32)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ bookkeeping
   int n_vec = 0;
   int n_err = 0;

   // backing-memory responder controls
   int fixed_lat   = 2;   // 0 = random latency 1..4 per word
   bit hold_ready  = 1'b0;
   bit spur_en     = 1'b0;
   int handshakes  = 0;

   // behavioural model: which line address each index currently holds
   bit          m_valid [8];
   logic [28:0] m_line  [8];
   bit          m_busy   = 1'b0;
   int          m_words  = 0;
   logic [28:0] m_fill_line = '0;
   bit          m_poison = 1'b0;
   int          m_fills  = 0;

   // samples taken in the most recent step
   logic        s_hit;
   logic [31:0] s_instr;
   logic        s_req;
   logic [31:0] s_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'hAAAA_1111;
      if (a == 32'h4) return 32'hBBBB_2222;
      return (a * 32'h9E37_79B1) ^ 32'h3C6E_F372;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_update(input logic rst_v, input logic [31:0] pc_v,
                               input logic inv_v, input logic rdy_v);
      logic hm;
      if (!rst_v) begin
         for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
         m_busy  = 1'b0;
         m_words = 0;
      end else if (m_busy) begin
         if (inv_v) for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
         if (rdy_v) begin
            if (m_words == 0) begin
               m_words = 1;
            end else begin
               m_busy  = 1'b0;
               m_words = 0;
               if (!m_poison && !inv_v) begin
                  m_valid[m_fill_line[2:0]] = 1'b1;
                  m_line[m_fill_line[2:0]]  = m_fill_line;
               end
            end
         end
         if (inv_v) m_poison = 1'b1;
      end else begin
         hm = m_valid[pc_v[5:3]] && (m_line[pc_v[5:3]] == pc_v[31:3]);
         if (inv_v) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
         end else if (!hm) begin
            m_busy      = 1'b1;
            m_words     = 0;
            m_fill_line = pc_v[31:3];
            m_poison    = 1'b0;
            m_fills++;
         end
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, compare against the
   // model shortly after, then advance the model at the rising edge.
   task automatic step(input logic rst_v, input logic [31:0] pc_v, input logic inv_v);
      logic        e_hit;
      logic [31:0] e_instr;
      @(negedge clk);
      reset       = rst_v;
      bus.pc_addr = pc_v;
      bus.inv_all = inv_v;
      #1;
      s_hit   = bus.hit;
      s_instr = bus.instr;
      s_req   = bus.mem_req;
      s_addr  = bus.mem_addr;
      e_hit   = !m_busy && m_valid[pc_v[5:3]] && (m_line[pc_v[5:3]] == pc_v[31:3]) && !inv_v;
      e_instr = e_hit ? mem_word({pc_v[31:2], 2'b00}) : 32'h0;
      chk("hit", {31'h0, s_hit}, {31'h0, e_hit});
      chk("instr", s_instr, e_instr);
      chk("mem_req", {31'h0, s_req}, {31'h0, m_busy});
      if (m_busy) chk("mem_addr", s_addr, {m_fill_line, 3'b000} + 32'(4 * m_words));
      @(posedge clk);
      model_update(rst_v, pc_v, inv_v, bus.mem_ready);
   endtask

   task automatic run_until_hit(input logic [31:0] pc_v, input int budget);
      bit done;
      done = 1'b0;
      for (int k = 0; k < budget; k++) begin
         step(1'b1, pc_v, 1'b0);
         if (s_hit === 1'b1) begin
            done = 1'b1;
            break;
         end
      end
      chk("hit_within_budget", {31'h0, done}, 32'h1);
   endtask

   task automatic run_until_addr(input logic [31:0] pc_v, input logic [31:0] a, input int budget);
      bit done;
      done = 1'b0;
      for (int k = 0; k < budget; k++) begin
         step(1'b1, pc_v, 1'b0);
         if (s_req === 1'b1 && s_addr === a) begin
            done = 1'b1;
            break;
         end
      end
      chk("addr_within_budget", {31'h0, done}, 32'h1);
   endtask

   // ---------------------------------------------------- backing memory
   initial begin
      int cnt;
      int lat;
      cnt = 0;
      lat = 1;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (bus.mem_req === 1'b1 && !hold_ready) begin
            if (cnt == 0) lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
            cnt++;
            if (cnt >= lat) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = mem_word(bus.mem_addr);
               cnt = 0;
               handshakes++;
            end else begin
               bus.mem_ready = 1'b0;
               bus.mem_rdata = $urandom;
            end
         end else begin
            // Stray ready pulses while idle must be ignored by the cache.
            bus.mem_ready = spur_en && (bus.mem_req !== 1'b1) && ($urandom_range(0, 2) == 0);
            bus.mem_rdata = $urandom;
            if (bus.mem_req !== 1'b1) cnt = 0;
         end
      end
   end

   // ---------------------------------------------------------- watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "simulation time limit exceeded");
   end

   // ---------------------------------------------------------- stimulus
   initial begin
      logic [31:0] t_req   [6] = '{0, 1, 1, 1, 1, 0};
      logic [31:0] t_addr  [6] = '{0, 0, 0, 4, 4, 4};
      logic [31:0] t_hit   [6] = '{0, 0, 0, 0, 0, 1};
      logic [31:0] t_instr [6] = '{0, 0, 0, 0, 0, 32'hAAAA_1111};
      logic [31:0] pc_r;
      logic        inv_r;
      logic        rst_r;
      int          h0;
      int          f0;

      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_line[i]  = '0;
      end
      reset       = 1'b0;
      bus.pc_addr = 32'h0;
      bus.inv_all = 1'b0;
      repeat (2) @(posedge clk);
      step(1'b0, 32'h0, 1'b0);

      // Cold miss at 0 with latency 2: hit at cycle 5
      fixed_lat = 2;
      for (int c = 0; c < 6; c++) begin
         step(1'b1, 32'h0, 1'b0);
         chk("t1_req", {31'h0, s_req}, t_req[c]);
         if (c < 5) chk("t1_addr", s_addr, t_addr[c]);
         chk("t1_hit", {31'h0, s_hit}, t_hit[c]);
         chk("t1_instr", s_instr, t_instr[c]);
      end
      step(1'b1, 32'h4, 1'b0);
      chk("t1_word1_hit", {31'h0, s_hit}, 32'h1);
      chk("t1_word1_instr", s_instr, 32'hBBBB_2222);
      $display("txn cold_fill: done, vectors=%0d", n_vec);

      // Conflict on index 0
      step(1'b1, 32'h40, 1'b0);
      chk("t2_conflict_miss", {31'h0, s_hit}, 32'h0);
      run_until_hit(32'h40, 20);
      step(1'b1, 32'h0, 1'b0);
      chk("t2_evicted_miss", {31'h0, s_hit}, 32'h0);
      run_until_hit(32'h0, 20);
      $display("txn conflict: done, vectors=%0d", n_vec);

      // Memory stalls in FILL0 for 10 cycles while pc wanders
      hold_ready = 1'b1;
      step(1'b1, 32'h100, 1'b0);
      for (int c = 0; c < 10; c++) begin
         step(1'b1, $urandom, 1'b0);
         chk("t3_req_held", {31'h0, s_req}, 32'h1);
         chk("t3_addr_held", s_addr, 32'h100);
      end
      hold_ready = 1'b0;
      run_until_hit(32'h100, 60);
      $display("txn stall: done, vectors=%0d", n_vec);

      // Invalidate in IDLE
      run_until_hit(32'h0, 20);
      step(1'b1, 32'h0, 1'b0);
      chk("t4_cached", {31'h0, s_hit}, 32'h1);
      chk("t4_cached_instr", s_instr, 32'hAAAA_1111);
      step(1'b1, 32'h0, 1'b1);
      chk("t4_inv_forces_miss", {31'h0, s_hit}, 32'h0);
      step(1'b1, 32'h0, 1'b0);
      chk("t4_after_inv_miss", {31'h0, s_hit}, 32'h0);
      step(1'b1, 32'h0, 1'b0);
      chk("t4_refill_req", {31'h0, s_req}, 32'h1);
      run_until_hit(32'h0, 20);

      // Invalidate during FILL1 poisons the line
      fixed_lat = 3;
      run_until_addr(32'h200, 32'h204, 20);
      step(1'b1, 32'h200, 1'b1);
      for (int k = 0; k < 10 && s_req === 1'b1; k++) step(1'b1, 32'h200, 1'b0);
      chk("t4_poison_idle", {31'h0, s_req}, 32'h0);
      chk("t4_poison_miss", {31'h0, s_hit}, 32'h0);
      step(1'b1, 32'h200, 1'b0);
      chk("t4_poison_refill", {31'h0, s_req}, 32'h1);
      run_until_hit(32'h200, 20);
      $display("txn invalidate: done, vectors=%0d", n_vec);

      // Reset during FILL1
      run_until_addr(32'h300, 32'h304, 20);
      step(1'b0, 32'h300, 1'b0);
      step(1'b1, 32'h0, 1'b0);
      chk("t5_req_dropped", {31'h0, s_req}, 32'h0);
      chk("t5_hit_low", {31'h0, s_hit}, 32'h0);
      run_until_hit(32'h0, 20);
      $display("txn reset_mid_fill: done, vectors=%0d", n_vec);

      // Sequential sweep of 16 lines with random latency
      fixed_lat = 0;
      h0 = handshakes;
      f0 = m_fills;
      for (int a = 32'h1000; a < 32'h1080; a += 4) run_until_hit(32'(a), 40);
      chk("t6_fills", 32'(m_fills - f0), 32'd16);
      chk("t6_handshakes", 32'(handshakes - h0), 32'd32);
      $display("txn sweep: fills=%0d handshakes=%0d vectors=%0d", m_fills - f0, handshakes - h0, n_vec);

      // Random traffic with invalidates, resets and stray ready pulses
      spur_en = 1'b1;
      pc_r    = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) < 3)
            pc_r = ($urandom_range(0, 1) != 0 ? 32'h8000_0000 : 32'h0)
                 + $urandom_range(0, 3) * 32'h40 + $urandom_range(0, 15) * 4;
         inv_r = ($urandom_range(0, 39) == 0);
         rst_r = ($urandom_range(0, 99) != 0);
         step(rst_r, pc_r, inv_r);
      end
      $display("txn random: fills=%0d vectors=%0d", m_fills, n_vec);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch_cache.md
# instr_fetch_cache

Instruction-side responder for the fetch stage. Serves each 32-bit fetch address as one 32-bit word holding two 16-bit instructions: memory-slot instruction in [31:16], ALU-slot instruction in [15:0]. Indicates a valid result with `hit`. On a miss, a small direct-mapped cache refills a two-word line from a backing memory over a req/ready handshake. While `hit` is low, the hazard logic holds the PC and the IF/ID register.

## Interface
Parameters:
- `INDEX_BITS`, 3 — log2 of line count (8 lines).
- `ADDR_W`, 32 — address width.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-low.
- `pc_addr`  in  32  — fetch byte address; bits [1:0] ignored.
- `inv_all`  in  1  — invalidate every line (self-modifying code / exception entry).
- `hit`  out  1  — `instr` is valid for `pc_addr` this cycle.
- `instr`  out  32  — fetched word; 32'h0 when `hit`=0.
- `mem_req`  out  1  — backing-memory read request.
- `mem_addr`  out  32  — word-aligned backing address, bits [1:0]=0.
- `mem_ready`  in  1  — one-cycle pulse: `mem_rdata` valid, request accepted.
- `mem_rdata`  in  32  — backing read data.

## Operation
- Address split:
  - word offset = `pc_addr[2]`
  - index = `pc_addr[2+INDEX_BITS:3]`
  - tag = `pc_addr[31:3+INDEX_BITS]`
- Per line storage: valid bit, tag, data word 0, data word 1.
- FSM states:
  - IDLE — lookup. `hit` = valid[index] & tag match. `instr` = data[index][offset]. On a miss (and `inv_all`=0), latch line base = {`pc_addr[31:3]`, 3'b000} and go to FILL0.
  - FILL0 — `mem_req`=1, `mem_addr`=base. On `mem_ready`: write word 0, go to FILL1.
  - FILL1 — `mem_req`=1, `mem_addr`=base+4. On `mem_ready`: write word 1, tag; set valid unless the fill is poisoned. Go to IDLE.
- `hit` is 0 outside IDLE.
- Handshake:
  - `mem_req` and `mem_addr` stay stable until the cycle `mem_ready` is sampled high.
  - `mem_req` drops in the cycle after the final `mem_ready`; there is no request in IDLE.
  - `mem_ready` while `mem_req`=0 is ignored.
- `pc_addr` changes during a fill are ignored. After returning to IDLE, lookup uses the current `pc_addr`; a different line causes a fresh miss.
- `inv_all`:
  - Clears all valid bits at the clock edge, in any state.
  - In IDLE, forces `hit`=0 that cycle and does not start a fill.
  - During FILL0/FILL1, the fill completes its handshakes, but the line is poisoned (not marked valid).
- Reset (low at edge):
  - Outputs: state IDLE, all valid bits 0, `mem_req`=0, `mem_addr`=0, `hit`=0, `instr`=0.
  - Data/tag arrays need no reset.
  - Reset mid-fill abandons the fill. `mem_req` is low the next cycle; the backing memory must tolerate a dropped request.

## Timing
- Hit: combinational, same cycle as `pc_addr` (zero-latency fetch).
- Miss, with backing ready latency L cycles per word (L≥1):
  - Miss seen in cycle 0.
  - `mem_req` high from cycle 1.
  - Word 0 at cycle L.
  - Word 1 at cycle 2L.
  - IDLE and `hit`=1 at cycle 2L+1.
- Back-to-back: a `mem_ready` in the cycle FILL0 is entered from IDLE is impossible, since `mem_req` is registered.
- Simultaneous `inv_all` and final `mem_ready` in FILL1: the line is not validated.

## Test plan
- Reset, then `pc_addr`=32'h0000_0000 → `hit`=0, `instr`=0, `mem_req`=1 next cycle, `mem_addr`=0 then 4. With L=2, `mem_rdata`=32'hAAAA_1111 then 32'hBBBB_2222 → at cycle 5 `hit`=1, `instr`=32'hAAAA_1111. `pc_addr`=4 → `hit`=1 same cycle, `instr`=32'hBBBB_2222.
- Conflict: fill 32'h0000_0000, then access 32'h0000_0040 (same index, different tag) → miss, refill. Back to 32'h0 → miss again.
- Hold `mem_ready`=0 for 10 cycles in FILL0 → `mem_req`=1 and `mem_addr` constant throughout. `pc_addr` toggling meanwhile has no effect on `mem_addr`.
- Fill line 0, then pulse `inv_all` → `hit`=0 next cycle at 32'h0 and a refill starts. `inv_all` during FILL1 → after completion `hit`=0 and a new fill is issued.
- `reset` low during FILL1 → next cycle `mem_req`=0, `hit`=0. After reset release, all prior lines miss.
- Sweep 16 sequential lines (128 bytes) with random L∈[1,4] → every returned `instr` matches the backing model; exactly two handshakes per miss.
